out_port: RTL and testbench

- Output stage of the SAP-1 datapath; consumes the 8-bit bus when the controller asserts the OUT-register load.
- Holds the last accepted byte on a parallel output for debug and probing.
- Serializes each accepted byte onto one pin as an 8N1 UART-style frame, since pin count on the heiChips tile is limited.
- Has a one-deep pending buffer so back-to-back OUT instructions are not lost.

---
 rtl/out_port_pkg.sv | 14 +
 rtl/out_port.sv | 150 +++++++++++++++
 tb/tb_out_port.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/out_port_pkg.sv
// rtl/out_port_pkg.sv - shared constants for the SAP-1 OUT register / serial output stage
//
// Holds the serializer state encoding and the OUT opcode used by the
// controller decode.
package out_port_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [3:0] OP_OUT = 4'hE;

endpackage

// File: rtl/out_port.sv
// rtl/out_port.sv - SAP-1 OUT register with 8N1 serializer and one-deep pending buffer
//
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high
//   load     capture bus this cycle
//   bus      8-bit shared datapath bus
//   out      last accepted byte (parallel, registered)
//   tx       serial line, idle high, 8N1 LSB first
//   busy     frame in flight or byte pending
//   overrun  sticky, set when a byte is dropped
module out_port
    import out_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] bus,
    output logic [7:0] out,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shreg, shreg_next;
    logic [7:0]       pend, pend_next;
    logic             pend_valid, pend_valid_next;
    logic [7:0]       out_next;
    logic             tx_next, overrun_next;
    logic             bit_end, stop_end;

    assign bit_end  = (baud_cnt == CNT_MAX);
    assign stop_end = (state == STOP) && bit_end;

    always_comb begin
        state_next      = state;
        bit_idx_next    = bit_idx;
        shreg_next      = shreg;
        pend_next       = pend;
        pend_valid_next = pend_valid;
        out_next        = out;
        tx_next         = tx;
        overrun_next    = overrun;
        // The baud counter free-runs while a frame is active; every bit
        // boundary wraps it, so a new frame always starts from zero.
        if (state == IDLE || bit_end) begin
            baud_next = '0;
        end else begin
            baud_next = baud_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (load) begin
                    shreg_next = bus;
                    out_next   = bus;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    tx_next      = shreg[0];
                    bit_idx_next = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        // tx always presents shreg[0]; shift to expose the next bit
                        shreg_next   = {1'b0, shreg[7:1]};
                        tx_next      = shreg[1];
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            default: begin
                if (bit_end) begin
                    if (pend_valid) begin
                        // Pending byte goes first; a coincident load refills the slot.
                        shreg_next      = pend;
                        state_next      = START;
                        tx_next         = 1'b0;
                        pend_valid_next = load;
                        if (load) begin
                            pend_next = bus;
                            out_next  = bus;
                        end
                    end else if (load) begin
                        shreg_next = bus;
                        out_next   = bus;
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
        endcase

        if (load && state != IDLE && !stop_end) begin
            if (!pend_valid) begin
                pend_next       = bus;
                pend_valid_next = 1'b1;
                out_next        = bus;
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'd0;
            pend       <= 8'd0;
            pend_valid <= 1'b0;
            out        <= 8'd0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_idx    <= bit_idx_next;
            shreg      <= shreg_next;
            pend       <= pend_next;
            pend_valid <= pend_valid_next;
            out        <= out_next;
            tx         <= tx_next;
            busy       <= (state_next != IDLE) || pend_valid_next;
            overrun    <= overrun_next;
        end
    end

endmodule

// File: tb/tb_out_port.sv
// tb/tb_out_port.sv - directed self-checking bench for out_port
module tb_out_port;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       load1 = 1'b0;
    logic [7:0] bus = 8'd0;
    logic [7:0] out, out1;
    logic       tx, busy, overrun;
    logic       tx1, busy1, overrun1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    out_port #(.CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .load(load), .bus(bus),
        .out(out), .tx(tx), .busy(busy), .overrun(overrun)
    );

    out_port #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .load(load1), .bus(bus),
        .out(out1), .tx(tx1), .busy(busy1), .overrun(overrun1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Expected line level k cycles after the start edge of an 8N1 frame.
    function automatic logic frame_bit(input logic [7:0] b, input int k, input int cpb);
        int slot;
        slot = k / cpb;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    initial begin
        // reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst tx", tx, 1);
        chk("rst out", out, 0);
        chk("rst busy", busy, 0);
        chk("rst overrun", overrun, 0);
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            chk($sformatf("idle tx k=%0d", k), tx, 1);
            chk($sformatf("idle busy k=%0d", k), busy, 0);
        end
        chk("idle out", out, 0);
        chk("idle overrun", overrun, 0);

        // single frame A5
        bus = 8'hA5; load = 1'b1; tick(); load = 1'b0;
        chk("a5 out", out, 8'hA5);
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("a5 tx k=%0d", k), tx, frame_bit(8'hA5, k, 4));
            chk($sformatf("a5 busy k=%0d", k), busy, 1);
            tick();
        end
        chk("a5 busy end", busy, 0);
        chk("a5 tx end", tx, 1);

        // back-to-back 3C then C3 at N+5
        bus = 8'h3C; load = 1'b1; tick(); load = 1'b0;
        for (int k = 0; k < 80; k++) begin
            chk($sformatf("b2b tx k=%0d", k), tx,
                (k < 40) ? frame_bit(8'h3C, k, 4) : frame_bit(8'hC3, k - 40, 4));
            chk($sformatf("b2b busy k=%0d", k), busy, 1);
            if (k == 5) chk("b2b out", out, 8'hC3);
            if (k == 4) begin bus = 8'hC3; load = 1'b1; end
            else load = 1'b0;
            tick();
        end
        chk("b2b busy end", busy, 0);
        chk("b2b overrun", overrun, 0);

        // overrun: 11, 22, 33 at N, N+2, N+4
        bus = 8'h11; load = 1'b1; tick(); load = 1'b0;
        for (int k = 0; k < 80; k++) begin
            chk($sformatf("ovr tx k=%0d", k), tx,
                (k < 40) ? frame_bit(8'h11, k, 4) : frame_bit(8'h22, k - 40, 4));
            chk($sformatf("ovr busy k=%0d", k), busy, 1);
            chk($sformatf("ovr flag k=%0d", k), overrun, (k >= 4) ? 1 : 0);
            chk($sformatf("ovr out k=%0d", k), out, (k >= 2) ? 8'h22 : 8'h11);
            if (k == 1) begin bus = 8'h22; load = 1'b1; end
            else if (k == 3) begin bus = 8'h33; load = 1'b1; end
            else load = 1'b0;
            tick();
        end
        chk("ovr busy end", busy, 0);
        chk("ovr sticky", overrun, 1);
        do_reset();
        chk("ovr cleared", overrun, 0);

        // load exactly on the final STOP edge
        bus = 8'h5A; load = 1'b1; tick(); load = 1'b0;
        for (int k = 0; k < 80; k++) begin
            chk($sformatf("edge tx k=%0d", k), tx,
                (k < 40) ? frame_bit(8'h5A, k, 4) : frame_bit(8'h7E, k - 40, 4));
            chk($sformatf("edge busy k=%0d", k), busy, 1);
            if (k == 40) chk("edge out", out, 8'h7E);
            if (k == 39) begin bus = 8'h7E; load = 1'b1; end
            else load = 1'b0;
            tick();
        end
        chk("edge busy end", busy, 0);
        chk("edge overrun", overrun, 0);

        // reset mid-frame with a pending byte, then a clean frame
        bus = 8'h0F; load = 1'b1; tick(); load = 1'b0;
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("mid tx k=%0d", k), tx, frame_bit(8'h0F, k, 4));
            if (k == 1) begin bus = 8'hAA; load = 1'b1; end
            else load = 1'b0;
            if (k == 14) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        chk("mid tx", tx, 1);
        chk("mid busy", busy, 0);
        chk("mid out", out, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("mid idle busy k=%0d", k), busy, 0);
            chk($sformatf("mid idle tx k=%0d", k), tx, 1);
        end
        bus = 8'h01; load = 1'b1; tick(); load = 1'b0;
        chk("post out", out, 8'h01);
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("post tx k=%0d", k), tx, frame_bit(8'h01, k, 4));
            chk($sformatf("post busy k=%0d", k), busy, 1);
            tick();
        end
        chk("post busy end", busy, 0);

        // CLKS_PER_BIT = 1: 10-cycle frame
        bus = 8'h96; load1 = 1'b1; tick(); load1 = 1'b0;
        chk("cpb1 out", out1, 8'h96);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("cpb1 tx k=%0d", k), tx1, frame_bit(8'h96, k, 1));
            chk($sformatf("cpb1 busy k=%0d", k), busy1, 1);
            tick();
        end
        chk("cpb1 busy end", busy1, 0);
        chk("cpb1 tx end", tx1, 1);
        chk("cpb1 overrun", overrun1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
